alarm_sequencer: RTL and testbench

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

---
 rtl/alarm_sequencer_if.sv | 26 ++
 rtl/alarm_sequencer.sv | 121 ++++++++++++
 tb/tb_alarm_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/alarm_sequencer_if.sv
// Alarm sequencer signal bundle.
//   master : drives alarm_match/alarm_enable/tick_1hz/snooze_btn/stop_btn,
//            observes buzzer/ringing/snoozing/snooze_count/missed
//   slave  : the sequencer itself (opposite directions)
interface alarm_sequencer_if;
  logic       alarm_match;
  logic       alarm_enable;
  logic       tick_1hz;
  logic       snooze_btn;
  logic       stop_btn;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_count;
  logic       missed;

  modport master (
    output alarm_match, alarm_enable, tick_1hz, snooze_btn, stop_btn,
    input  buzzer, ringing, snoozing, snooze_count, missed
  );

  modport slave (
    input  alarm_match, alarm_enable, tick_1hz, snooze_btn, stop_btn,
    output buzzer, ringing, snoozing, snooze_count, missed
  );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: IDLE -> RINGING on an armed alarm_match rising edge,
// RINGING <-> SNOOZE via snooze button / snooze timeout, auto-stop after
// RING_TIMEOUT_S seconds of unattended ringing (sets sticky missed flag).
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : alarm_sequencer_if.slave (level inputs, registered outputs)
module alarm_sequencer #(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic             clk,
  input  logic             reset,
  alarm_sequencer_if.slave bus
);
  localparam int CNT_MAX = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] RING_LAST = CW'(RING_TIMEOUT_S - 1);
  localparam logic [CW-1:0] SNZ_LAST  = CW'(SNOOZE_S - 1);
  localparam logic [1:0]    SNZ_LIMIT = 2'(MAX_SNOOZE);

  // Encoding chosen so ringing/snoozing are state flop bits directly.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RING = 2'b01;
  localparam logic [1:0] ST_SNZ  = 2'b10;

  logic [1:0]    state;
  logic [CW-1:0] sec;
  logic [1:0]    snz_cnt;
  logic          buzz, miss;
  logic          match_q, snz_q, stop_q;

  wire match_e = bus.alarm_match & ~match_q;
  wire snz_e   = bus.snooze_btn  & ~snz_q;
  wire stop_e  = bus.stop_btn    & ~stop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      sec     <= '0;
      snz_cnt <= '0;
      buzz    <= 1'b0;
      miss    <= 1'b0;
      match_q <= 1'b0;
      snz_q   <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      match_q <= bus.alarm_match;
      snz_q   <= bus.snooze_btn;
      stop_q  <= bus.stop_btn;

      case (state)
        ST_RING: begin
          if (!bus.alarm_enable) begin
            state <= ST_IDLE;
            buzz  <= 1'b0;
          end else if (stop_e) begin
            state <= ST_IDLE;
            buzz  <= 1'b0;
            miss  <= 1'b0;
          end else if (snz_e && (snz_cnt < SNZ_LIMIT)) begin
            state   <= ST_SNZ;
            snz_cnt <= snz_cnt + 2'd1;
            sec     <= '0;
            buzz    <= 1'b0;
          end else if (bus.tick_1hz) begin
            // A snooze press beyond the limit falls through here so the
            // same-cycle tick still advances the ring timer.
            if (sec == RING_LAST) begin
              state <= ST_IDLE;
              buzz  <= 1'b0;
              miss  <= 1'b1;
            end else begin
              sec  <= sec + CW'(1);
              buzz <= ~buzz;
            end
          end
        end

        ST_SNZ: begin
          if (!bus.alarm_enable) begin
            state <= ST_IDLE;
          end else if (stop_e) begin
            state <= ST_IDLE;
          end else if (bus.tick_1hz) begin
            if (sec == SNZ_LAST) begin
              state <= ST_RING;
              sec   <= '0;
              buzz  <= 1'b1;
            end else begin
              sec <= sec + CW'(1);
            end
          end
        end

        ST_IDLE: begin
          if (stop_e) miss <= 1'b0;
          if (bus.alarm_enable && match_e) begin
            state   <= ST_RING;
            sec     <= '0;
            snz_cnt <= '0;
            buzz    <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          buzz  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ringing      = state[0];
  assign bus.snoozing     = state[1];
  assign bus.buzzer       = buzz;
  assign bus.snooze_count = snz_cnt;
  assign bus.missed       = miss;
endmodule

// File: tb/tb_alarm_sequencer.sv
module tb_alarm_sequencer;
  typedef struct {
    logic       r;
    logic       s;
    logic       b;
    logic [1:0] c;
    logic       m;
    int         id;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   step = 0;
  exp_t q[$];

  alarm_sequencer_if bus ();

  alarm_sequencer #(.RING_TIMEOUT_S(4), .SNOOZE_S(3), .MAX_SNOOZE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, id, act, exp);
    end
  endtask

  task automatic chk_all(input int id, input logic r, input logic s, input logic b,
                         input logic [1:0] c, input logic m);
    chk("ringing",      id, {1'b0, bus.ringing},  {1'b0, r});
    chk("snoozing",     id, {1'b0, bus.snoozing}, {1'b0, s});
    chk("buzzer",       id, {1'b0, bus.buzzer},   {1'b0, b});
    chk("snooze_count", id, bus.snooze_count,     c);
    chk("missed",       id, {1'b0, bus.missed},   {1'b0, m});
  endtask

  task automatic expect_out(input logic r, input logic s, input logic b,
                            input logic [1:0] c, input logic m);
    exp_t e;
    step++;
    e.r = r; e.s = s; e.b = b; e.c = c; e.m = m; e.id = step;
    q.push_back(e);
  endtask

  // Drive one clock of inputs and queue the outputs expected after that edge.
  task automatic cyc(input logic en, input logic mt, input logic tk, input logic sz,
                     input logic sp, input logic r, input logic s, input logic b,
                     input logic [1:0] c, input logic m);
    @(negedge clk);
    bus.alarm_enable = en;
    bus.alarm_match  = mt;
    bus.tick_1hz     = tk;
    bus.snooze_btn   = sz;
    bus.stop_btn     = sp;
    expect_out(r, s, b, c, m);
  endtask

  // Monitor: outputs are presented on every edge; compare whatever is queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk_all(e.id, e.r, e.s, e.b, e.c, e.m);
      end
    end
  end

  initial begin
    bus.alarm_enable = 1'b0;
    bus.alarm_match  = 1'b0;
    bus.tick_1hz     = 1'b0;
    bus.snooze_btn   = 1'b0;
    bus.stop_btn     = 1'b0;
    #1 reset = 1'b0;
    #2 chk_all(0, 0, 0, 0, 2'd0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    //  en mt tk sz sp   r  s  b  cnt m
    // ring, time out after 4 ticks, stop in IDLE clears missed
    cyc(1, 0, 0, 0, 0,  0, 0, 0, 2'd0, 0);
    cyc(1, 1, 0, 0, 0,  1, 0, 1, 2'd0, 0);
    cyc(1, 0, 1, 0, 0,  1, 0, 0, 2'd0, 0);
    cyc(1, 0, 1, 0, 0,  1, 0, 1, 2'd0, 0);
    cyc(1, 0, 0, 0, 0,  1, 0, 1, 2'd0, 0);
    cyc(1, 0, 1, 0, 0,  1, 0, 0, 2'd0, 0);
    cyc(1, 0, 1, 0, 0,  0, 0, 0, 2'd0, 1);
    cyc(1, 0, 0, 0, 1,  0, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 0, 0,  0, 0, 0, 2'd0, 0);
    // snooze, back to ringing after 3 ticks
    cyc(1, 1, 0, 0, 0,  1, 0, 1, 2'd0, 0);
    cyc(1, 0, 0, 1, 0,  0, 1, 0, 2'd1, 0);
    cyc(1, 0, 1, 0, 0,  0, 1, 0, 2'd1, 0);
    cyc(1, 0, 1, 0, 0,  0, 1, 0, 2'd1, 0);
    cyc(1, 0, 1, 0, 0,  1, 0, 1, 2'd1, 0);
    // second snooze, then a third is ignored; stop keeps count
    cyc(1, 0, 0, 1, 0,  0, 1, 0, 2'd2, 0);
    cyc(1, 0, 1, 0, 0,  0, 1, 0, 2'd2, 0);
    cyc(1, 0, 1, 0, 0,  0, 1, 0, 2'd2, 0);
    cyc(1, 0, 1, 0, 0,  1, 0, 1, 2'd2, 0);
    cyc(1, 0, 0, 1, 0,  1, 0, 1, 2'd2, 0);
    cyc(1, 0, 0, 0, 0,  1, 0, 1, 2'd2, 0);
    cyc(1, 0, 0, 0, 1,  0, 0, 0, 2'd2, 0);
    cyc(1, 0, 0, 0, 0,  0, 0, 0, 2'd2, 0);
    // stop and snooze together: stop wins, count unchanged
    cyc(1, 1, 0, 0, 0,  1, 0, 1, 2'd0, 0);
    cyc(1, 0, 0, 1, 0,  0, 1, 0, 2'd1, 0);
    cyc(1, 0, 1, 0, 0,  0, 1, 0, 2'd1, 0);
    cyc(1, 0, 1, 0, 0,  0, 1, 0, 2'd1, 0);
    cyc(1, 0, 1, 0, 0,  1, 0, 1, 2'd1, 0);
    cyc(1, 0, 0, 1, 1,  0, 0, 0, 2'd1, 0);
    cyc(1, 0, 0, 0, 0,  0, 0, 0, 2'd1, 0);
    // alarm_match held high after stop must not retrigger
    cyc(1, 1, 0, 0, 0,  1, 0, 1, 2'd0, 0);
    cyc(1, 1, 0, 0, 1,  0, 0, 0, 2'd0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 0,  0, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 0, 0,  0, 0, 0, 2'd0, 0);
    // enable low during SNOOZE forces IDLE; disarmed match edge ignored
    cyc(1, 1, 0, 0, 0,  1, 0, 1, 2'd0, 0);
    cyc(1, 0, 0, 1, 0,  0, 1, 0, 2'd1, 0);
    cyc(0, 0, 0, 0, 0,  0, 0, 0, 2'd1, 0);
    cyc(0, 1, 0, 0, 0,  0, 0, 0, 2'd1, 0);
    cyc(1, 0, 0, 0, 0,  0, 0, 0, 2'd1, 0);
    // timeout then enable low: missed stays set
    cyc(1, 1, 0, 0, 0,  1, 0, 1, 2'd0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0,  1, 0, i[0], 2'd0, 0);
    cyc(1, 0, 1, 0, 0,  0, 0, 0, 2'd0, 1);
    cyc(1, 1, 0, 0, 0,  1, 0, 1, 2'd0, 1);
    cyc(0, 0, 0, 0, 0,  0, 0, 0, 2'd0, 1);
    cyc(1, 0, 0, 0, 0,  0, 0, 0, 2'd0, 1);
    // async reset mid-RINGING between edges
    cyc(1, 1, 0, 0, 0,  1, 0, 1, 2'd0, 1);
    cyc(1, 0, 1, 0, 0,  1, 0, 0, 2'd0, 1);
    @(posedge clk);
    #3;
    bus.tick_1hz = 1'b0;
    reset = 1'b0;
    #1 chk_all(-1, 0, 0, 0, 2'd0, 0);
    // match held high across reset release counts as a rising edge
    bus.alarm_match = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    expect_out(1, 0, 1, 2'd0, 0);
    cyc(1, 1, 0, 0, 0,  1, 0, 1, 2'd0, 0);
    cyc(1, 1, 1, 0, 0,  1, 0, 0, 2'd0, 0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
